mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Sequential signed multiply/divide responder that owns the HI and LO registers of the multicycle MIPS datapath.
- The control unit initiates an operation with a one-cycle start pulse, waits on busy, and continues on done.
- The operands come from the A and B register outputs.
- hi/lo feed the register-write-data mux for mfhi/mflo.
- div_zero feeds the control unit's divide-by-zero exception path.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only while idle.
- op  in  1  operation select: 0 = mult (signed), 1 = div (signed).
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with done, when the divisor is 0.
- hi  out  WIDTH  mult: product[63:32]; div: remainder.
- lo  out  WIDTH  mult: product[31:0]; div: quotient.

Behaviour:
- One clock domain, clk. reset is asynchronous and active-low.
- While reset is low: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, internal operand registers=0.
- States are IDLE, MULT and DIV.
- IDLE behaviour at edge E0 when start=1:
  - a, b and op are latched at E0; later changes on the inputs have no effect.
  - op=0: go to MULT with counter=0.
  - op=1 and b!=0: take magnitudes of a and b, record the quotient sign (a[31]^b[31]) and remainder sign (a[31]), go to DIV.
  - op=1 and b==0: stay in IDLE; after E0, done=1 and div_zero=1 for one cycle; hi and lo keep their previous values.
- MULT: radix-2 Booth, one step per edge, WIDTH steps. Result is the exact signed 64-bit product.
- DIV: unsigned restoring division on the magnitudes, one quotient bit per edge, WIDTH steps.
  - Final quotient is negated if the quotient sign is set.
  - Final remainder is negated if the remainder sign is set.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- Latency:
  - busy=1 from after E0 through the final step edge E32.
  - At E32, hi and lo are written, state returns to IDLE, busy=0, and done=1 for the cycle after E32.
  - Total latency is 33 edges.
- hi and lo change only at completion or reset. Intermediate partial results never appear on hi or lo.
- start while busy=1 is ignored; it is neither queued nor an error.
- start in the cycle where done=1 is accepted, because state is already IDLE. This gives back-to-back operation.
- done and div_zero are registered outputs and are never high for more than one cycle per request.
- A reset assertion mid-operation aborts the operation immediately. No done pulse is generated, and hi/lo clear to 0.
- An op value latched at E0 selects the operation for its whole duration.

Decomposition:
- Shared package mult_div_pkg holds:
  - op encodings OP_MULT=1'b0 and OP_DIV=1'b1;
  - the state enum (IDLE, MULT, DIV);
  - the WIDTH default constant.
- One natural sub-module: div_restoring_step, a combinational trial-subtract/shift for a single quotient bit, instantiated once.
- The Booth step stays inline in mult_div_unit.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3): busy is high 32 cycles, done pulses 33 edges after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- mult a=0x80000000, b=0x80000000: hi=0x40000000, lo=0x00000000. Then div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- div a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). div 7 / -2: lo=0xFFFFFFFD, hi=1.
- Divide by zero after a prior mult left hi=0x1234, lo=0x5678: div 5 / 0 gives done=1 and div_zero=1 in the cycle after start, busy stays 0, hi=0x1234, lo=0x5678 unchanged.
- start with op=1, a=100, b=7 pulsed at cycles 5 and 20 of an in-flight mult: both ignored, and the mult result is correct. A start in the done cycle (div 100/7) is accepted and gives lo=14, hi=2.
- reset driven low at cycle 10 of a div: busy, done and div_zero go to 0 and hi/lo go to 0 asynchronously, with no done pulse. After release, a new mult 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings for the signed multiply/divide unit: op select, FSM states, default width.
package mult_div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
// Purely combinational; no flow control.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so diff[WIDTH] is exactly the borrow
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// Signed mult (radix-2 Booth) / div (restoring) owning HI/LO; done pulses 33 edges after start.
// start is sampled only in IDLE; starts while busy are dropped, divide-by-zero completes next cycle.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   work_hi;  // Booth accumulator (sign-extended) or division remainder
  logic [WIDTH-1:0] work_lo;  // Booth multiplier/product low or dividend/quotient
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic             booth_q1;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_hi;
  logic [WIDTH-1:0] booth_lo;

  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  // Extra accumulator bit keeps acc - m exact when m is the most negative value
  assign m_ext = {opnd[WIDTH-1], opnd};

  always_comb begin
    booth_sum = work_hi;
    case ({work_lo[0], booth_q1})
      2'b01:   booth_sum = work_hi + m_ext;
      2'b10:   booth_sum = work_hi - m_ext;
      default: booth_sum = work_hi;
    endcase
  end

  assign booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_lo = {booth_sum[0], work_lo[WIDTH-1:1]};

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (work_hi[WIDTH-1:0]),
    .quo_in  (work_lo),
    .divisor (opnd),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      opnd     <= '0;
      booth_q1 <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            work_hi <= '0;
            if (op == OP_MULT) begin
              work_lo  <= b;
              opnd     <= a;
              booth_q1 <= 1'b0;
              busy     <= 1'b1;
              state    <= MULT;
            end else if (b == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              work_lo <= a_mag;
              opnd    <= b_mag;
              q_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg   <= a[WIDTH-1];
              busy    <= 1'b1;
              state   <= DIV;
            end
          end
        end
        MULT: begin
          work_hi  <= booth_hi;
          work_lo  <= booth_lo;
          booth_q1 <= work_lo[0];
          cnt      <= cnt + 1'b1;
          if (last) begin
            hi    <= booth_hi[WIDTH-1:0];
            lo    <= booth_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        DIV: begin
          work_hi <= {1'b0, div_rem};
          work_lo <= div_quo;
          cnt     <= cnt + 1'b1;
          if (last) begin
            hi    <= r_neg ? -div_rem : div_rem;
            lo    <= q_neg ? -div_quo : div_quo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: table of signed mult/div cases plus ignore-while-busy,
// back-to-back and mid-operation reset sequences.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;

  mult_div_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request, optionally pulsing extra (ignored) div starts at the given edge counts,
  // and returns edges from the start edge to the done cycle plus the busy-cycle count.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input int inj1, input int inj2,
                        output int edges, output int busy_cnt, output logic dz_seen);
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic        stable;
    prev_hi = hi;
    prev_lo = lo;
    stable  = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    edges    = 1;
    busy_cnt = 0;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
      start = (edges == inj1 || edges == inj2);
      if (start) begin
        op = 1'b1; a = 32'd100; b = 32'd7;
      end else begin
        op = ~o; a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      edges++;
    end
    start   = 1'b0;
    dz_seen = div_zero;
    check("done_seen", {31'b0, done}, 32'd1);
    check("hilo_stable_while_busy", {31'b0, stable}, 32'd1);
  endtask

  int   edges;
  int   bcnt;
  logic dz;

  initial begin
    n_vec = 0;
    n_err = 0;
    start = 1'b0; op = 1'b0; a = '0; b = '0;

    vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[3]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{1'b0, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};
    vecs[6]  = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000012, 32'h34567800, 1'b1};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[8]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[9]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
    vecs[11] = '{1'b1, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{1'b1, 32'h7FFFFFFF, 32'h00000010, 32'h0000000F, 32'h07FFFFFF, 1'b0};

    reset = 1'b0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, edges, bcnt, dz);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_div_zero", i), {31'b0, dz}, {31'b0, vecs[i].dz});
      check($sformatf("v%0d_latency", i), edges, vecs[i].dz ? 32'd1 : 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].dz ? 32'd0 : 32'd32);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d_dz_one_cycle", i), {31'b0, div_zero}, 32'd0);
    end

    // Starts mid-flight are dropped; a start in the done cycle is taken.
    run_op(1'b0, 32'h00001234, 32'h00000010, 5, 20, edges, bcnt, dz);
    check("ign_hi", hi, 32'h00000000);
    check("ign_lo", lo, 32'h00012340);
    check("ign_latency", edges, 32'd33);
    run_op(1'b1, 32'd100, 32'd7, 0, 0, edges, bcnt, dz);
    check("b2b_hi", hi, 32'd2);
    check("b2b_lo", lo, 32'd14);
    check("b2b_latency", edges, 32'd33);
    @(posedge clk); #1;

    // Reset in the middle of a divide aborts it and clears hi/lo without waiting for an edge.
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_div_zero", {31'b0, div_zero}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) check("abort_no_done", {31'b0, done}, 32'd0);
    end
    run_op(1'b0, 32'd3, 32'd4, 0, 0, edges, bcnt, dz);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd12);
    check("post_rst_latency", edges, 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
